uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter among N_SRC message generators: the RDM reporter, status, path and debug senders.
- Each source keeps its own tx_start/tx_msg/tx_done byte handshake and a message-level active flag.
- Grants the UART per whole message, round-robin, so messages never interleave.
- Inserts a programmable idle gap between messages.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- GAP_CYCLES, 16, idle clocks between end of one message and next grant; 0 = no gap.
- TIMEOUT_CYCLES, 50000, owner-stall limit in clocks (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- src_active  in  N_SRC  per-source "message in progress" flag (e.g. RDM_active).
- src_start  in  N_SRC  per-source one-cycle byte start pulse.
- src_data  in  8*N_SRC  per-source byte; source i uses bits [8i+7:8i].
- src_done  out  N_SRC  one-cycle byte-done pulse back to the owning source.
- uart_start  out  1  one-cycle start pulse to the UART transmitter.
- uart_data  out  8  byte to the UART, valid from the uart_start cycle until uart_done.
- uart_done  in  1  one-cycle pulse from the UART at the end of a byte.
- grant  out  N_SRC  one-hot current owner; all zero when no owner.
- busy  out  1  high whenever state != IDLE.
- ovf_err  out  1  one-cycle pulse when a byte is dropped.
- timeout  out  1  one-cycle pulse on forced release (0 when feature off).

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, grant=0, rr_ptr=0, pend=0, gap counter=0.
  - All outputs 0; uart_data=8'h00.
  - Reset mid-byte abandons the byte without a src_done.
- Capture:
  - Each source has a 1-entry holding register.
  - src_start[i] latches src_data[i] and sets pend[i], regardless of grant. This covers sources that raise src_active and src_start in the same cycle.
  - src_start[i] while pend[i]=1: byte dropped, holding register unchanged, ovf_err pulses.
- Eligibility: elig[i] = src_active[i] | pend[i].
- IDLE:
  - If any elig: grant the first eligible index searching rr_ptr, rr_ptr+1, ... mod N_SRC.
  - Set rr_ptr = winner+1 mod N_SRC, go to ISSUE. Grant appears 1 clk after eligibility.
- ISSUE:
  - If pend[owner]: pulse uart_start, drive uart_data = hold[owner], clear pend[owner], go to WAIT.
  - Else if src_active[owner]=0: release, grant=0, go to GAP (or IDLE if GAP_CYCLES=0).
  - Else stay.
- WAIT:
  - On uart_done: pulse src_done[owner] in the same cycle (combinational from uart_done & grant), go to ISSUE.
  - src_active dropping during WAIT has no effect until the byte completes.
- GAP: count GAP_CYCLES clocks with grant=0, then go to IDLE.
- Latency:
  - src_start of the owner in ISSUE to uart_start: 2 clks (capture, issue).
  - uart_done to src_done: 0 clks.
- Simultaneous events:
  - src_start and uart_done in the same cycle are both honoured.
  - A new src_start for the owner arriving in the same cycle its pend clears is captured (set wins).
- Non-owners never see src_done. Their pending byte waits until they win a grant.
- uart_done outside WAIT is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Counter runs in ISSUE while the owner has src_active=1 and pend=0; it resets on every issue.
  - Reaching TIMEOUT_CYCLES forces release: grant=0, pulse timeout, go to GAP, pend[owner] cleared.
- Undefined: no counter; the owner holds the UART indefinitely; timeout tied 0.

Test Plan:
- Single source 0 sends the 10 bytes "RDM-PSU1-#"; UART model returns uart_done 20 clks after each start -> uart_data sequence 52 44 4D 2D 50 53 55 31 2D 23, 10 src_done[0] pulses, grant=0001 throughout, busy falls 16 clks after release.
- Sources 1 and 2 both assert active+start on the same cycle after reset -> source 1 is granted first; source 2's first byte is held and sent only after source 1's message and the 16-clk gap; no interleaving.
- Continuous requests from all 4 sources -> grant order 0,1,2,3,0.
- Source 3 pulses src_start twice without an intervening done while not granted -> one ovf_err pulse; only the first byte is transmitted.
- rst_n low during WAIT of byte 5 -> all outputs 0 immediately; after release the arbiter is IDLE with rr_ptr=0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: owner holds active with no start -> timeout pulse at clk 100 and the next source is granted after the gap. Without the macro: the grant is held.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one UART byte TX.
// Define ARB_TIMEOUT_EN to force release of an owner that stalls in ISSUE.
module uart_tx_arbiter #(
  parameter int N_SRC          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   src_active,
  input  logic [N_SRC-1:0]   src_start,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_done,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_done,
  output logic [N_SRC-1:0]   grant,
  output logic               busy,
  output logic               ovf_err,
  output logic               timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_e;

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q;
  logic [N_SRC-1:0] grant_q;
  logic [PW-1:0]    rr_q;
  logic [GW-1:0]    gap_q;
  logic             uart_start_q;
  logic [7:0]       data_q;

  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] pend_clr;
  logic [N_SRC-1:0] pend_keep;
  logic [7:0]       hold_q [N_SRC];
  logic             ovf_q;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] win_oh;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    rr_next;
  logic             win_any;
  logic             own_pend;
  logic             own_active;
  logic [7:0]       own_byte;
  logic             issue;
  logic             to_fire;

  assign elig       = src_active | pend_q;
  assign own_pend   = |(pend_q & grant_q);
  assign own_active = |(src_active & grant_q);
  assign issue      = (state_q == ISSUE) && own_pend;

  // first eligible index at or after rr_q, wrapping
  always_comb begin
    int idx;
    win_any = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!win_any && elig[idx]) begin
        win_any = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  assign win_oh  = N_SRC'(1) << win_idx;
  assign rr_next = (win_idx == PW'(N_SRC - 1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    own_byte = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) own_byte = hold_q[i];
    end
  end

  // a start landing on the cycle its pend clears is a capture, not a drop
  assign pend_clr  = (issue || to_fire) ? grant_q : '0;
  assign pend_keep = pend_q & ~pend_clr;
  assign pend_d    = src_start | pend_keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < N_SRC; i++) hold_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= |(src_start & pend_keep);
      for (int i = 0; i < N_SRC; i++) begin
        if (src_start[i] && !pend_keep[i]) begin
          hold_q[i] <= src_data[8*i +: 8];
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_q;
  logic          to_pulse_q;
  logic          stall;

  assign stall   = (state_q == ISSUE) && !own_pend && own_active;
  assign to_fire = stall && (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q       <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= to_fire;
      if (stall && !to_fire) to_q <= to_q + TW'(1);
      else                   to_q <= '0;
    end
  end

  assign timeout = to_pulse_q;
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      gap_q        <= '0;
      uart_start_q <= 1'b0;
      data_q       <= '0;
    end else begin
      uart_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_any) begin
            grant_q <= win_oh;
            rr_q    <= rr_next;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (own_pend) begin
            uart_start_q <= 1'b1;
            data_q       <= own_byte;
            state_q      <= WAIT;
          end else if (!own_active || to_fire) begin
            grant_q <= '0;
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end
        end
        WAIT: begin
          if (uart_done) state_q <= ISSUE;
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_done   = (state_q == WAIT && uart_done) ? grant_q : '0;
  assign uart_start = uart_start_q;
  assign uart_data  = data_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign ovf_err    = ovf_q;

endmodule
